// File: rtl/roll_pkg.sv
// Shared types and constants for the roll capture block: FSM state encoding,
// result type and the hex-to-seven-segment lookup table.
package roll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    typedef logic [3:0] result_t;

    // Active-low segments ordered {g,f,e,d,c,b,a}, indexed by hex digit.
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/roll_capture_if.sv
// Bus between the roll capture block and its user. Strobe/pulse semantics:
// i_start is a one-cycle strobe sampled on the rising edge (no ready, it is
// always accepted); o_done is a one-cycle pulse coincident with o_result
// becoming the newly settled value.
interface roll_capture_if;
    logic                  i_start;
    logic [3:0]            i_rand;
    roll_pkg::result_t     o_result;
    logic                  o_done;
    logic                  o_valid;
    logic                  o_busy;
    logic [6:0]            o_seg;
    logic [7:0]            o_rolls;
    logic [15:0]           o_hist;
    roll_pkg::state_t      dbg_state;

    modport master (
        output i_start, i_rand,
        input  o_result, o_done, o_valid, o_busy, o_seg, o_rolls, o_hist, dbg_state
    );

    modport slave (
        input  i_start, i_rand,
        output o_result, o_done, o_valid, o_busy, o_seg, o_rolls, o_hist, dbg_state
    );
endinterface

// File: rtl/seg7_dec.sv
// Combinational hex to active-low seven-segment decoder with a blank input.
module seg7_dec
    import roll_pkg::*;
(
    input  result_t    i_val,
    input  logic       i_blank,
    output logic [6:0] o_seg
);
    assign o_seg = i_blank ? SEG_BLANK : SEG_TABLE[i_val];
endmodule

// File: rtl/roll_capture.sv
// Watches a free-running random value after a start strobe and captures it once
// it has held steady for SETTLE_CYC samples. History register is built only
// when ROLL_CAPTURE_HIST_EN is defined; otherwise o_hist is tied to zero.
module roll_capture
    import roll_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    roll_capture_if.slave  bus
);
    localparam int CW = $clog2(SETTLE_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYC - 1);

    state_t          state_q, state_d;
    result_t         prev_q, prev_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    result_t         result_q;
    logic            done_q;
    logic            valid_q;
    logic [7:0]      rolls_q;
    logic            same;
    logic            at_max;
    logic            busy;
    logic            settle;

    assign same   = (bus.i_rand == prev_q);
    assign at_max = (cnt_q == CNT_MAX);

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; a start strobe always wins, including mid-track re-rolls
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (bus.i_start) state_d = ST_TRACK;
            end
            ST_TRACK: begin
                if (!bus.i_start && same && at_max) state_d = ST_HOLD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy   = (state_q == ST_TRACK);
        settle = busy && !bus.i_start && same && at_max;
    end

    // Stability tracker; the counter stops at CNT_MAX because settling leaves TRACK
    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        if (bus.i_start) begin
            prev_d = bus.i_rand;
            cnt_d  = '0;
        end else if (busy) begin
            if (!same) begin
                prev_d = bus.i_rand;
                cnt_d  = '0;
            end else if (!settle) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            rolls_q  <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            done_q <= settle;
            if (settle) begin
                result_q <= prev_q;
                valid_q  <= 1'b1;
                if (rolls_q != 8'hFF) rolls_q <= rolls_q + 8'd1;
            end
        end
    end

`ifdef ROLL_CAPTURE_HIST_EN
    logic [15:0] hist_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist_q <= '0;
        end else if (settle) begin
            hist_q <= {hist_q[11:0], prev_q};
        end
    end

    assign bus.o_hist = hist_q;
`else
    assign bus.o_hist = 16'h0000;
`endif

    seg7_dec u_seg (
        .i_val   (result_q),
        .i_blank (!valid_q),
        .o_seg   (bus.o_seg)
    );

    assign bus.o_result  = result_q;
    assign bus.o_done    = done_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_busy    = busy;
    assign bus.o_rolls   = rolls_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_roll_capture.sv
// Directed bench for roll_capture at the default SETTLE_CYC of 16.
module tb_roll_capture;
    import roll_pkg::*;

    logic i_clk;
    logic i_rst_n;
    int   checks;
    int   failures;

    roll_capture_if bus();

    roll_capture dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Waits up to budget edges for o_done; n is the edge index it was seen on, -1 on timeout.
    task automatic wait_done(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge i_clk);
            #1;
            if (bus.o_done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Issues a start with value v held, returns settle latency in edges after the start edge.
    task automatic do_roll(input logic [3:0] v, output int n);
        bus.i_start = 1'b1;
        bus.i_rand  = v;
        @(posedge i_clk);
        #1;
        bus.i_start = 1'b0;
        wait_done(40, n);
    endtask

    task automatic apply_reset();
        i_rst_n     = 1'b0;
        bus.i_start = 1'b0;
        bus.i_rand  = 4'h0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int done_seen;
        apply_reset();
        #1;
        checks++; if (bus.o_result !== 4'h0) begin failures++; $display("FAIL reset_result: got %0h exp 0", bus.o_result); end
        checks++; if (bus.o_rolls !== 8'h00) begin failures++; $display("FAIL reset_rolls: got %0h exp 0", bus.o_rolls); end
        checks++; if (bus.o_hist !== 16'h0000) begin failures++; $display("FAIL reset_hist: got %0h exp 0", bus.o_hist); end
        checks++; if (bus.dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d exp %0d", bus.dbg_state, ST_IDLE); end
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge i_clk);
            #1;
            if (bus.o_done !== 1'b0) done_seen++;
        end
        checks++; if (done_seen != 0) begin failures++; $display("FAIL idle_done: got %0d pulses exp 0", done_seen); end
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL idle_valid: got %0b exp 0", bus.o_valid); end
        checks++; if (bus.o_seg !== 7'h7F) begin failures++; $display("FAIL idle_seg: got %0h exp 7f", bus.o_seg); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %0b exp 0", bus.o_busy); end
    endtask

    task automatic test_single_roll();
        int n;
        bus.i_start = 1'b1;
        bus.i_rand  = 4'h5;
        @(posedge i_clk);
        #1;
        bus.i_start = 1'b0;
        checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %0b exp 1", bus.o_busy); end
        wait_done(40, n);
        checks++; if (n != 16) begin failures++; $display("FAIL single_latency: got %0d exp 16", n); end
        checks++; if (bus.o_result !== 4'h5) begin failures++; $display("FAIL single_result: got %0h exp 5", bus.o_result); end
        checks++; if (bus.o_seg !== 7'h12) begin failures++; $display("FAIL single_seg: got %0h exp 12", bus.o_seg); end
        checks++; if (bus.o_rolls !== 8'd1) begin failures++; $display("FAIL single_rolls: got %0d exp 1", bus.o_rolls); end
        checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %0b exp 1", bus.o_valid); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL single_busy_after: got %0b exp 0", bus.o_busy); end
        // In HOLD the input must be ignored and the pulse must drop
        bus.i_rand = 4'hC;
        @(posedge i_clk);
        #1;
        checks++; if (bus.o_done !== 1'b0) begin failures++; $display("FAIL single_done_width: got %0b exp 0", bus.o_done); end
        repeat (20) @(posedge i_clk);
        #1;
        checks++; if (bus.o_result !== 4'h5) begin failures++; $display("FAIL hold_result: got %0h exp 5", bus.o_result); end
        checks++; if (bus.dbg_state !== ST_HOLD) begin failures++; $display("FAIL hold_state: got %0d exp %0d", bus.dbg_state, ST_HOLD); end
    endtask

    task automatic test_toggle();
        int n;
        int done_seen;
        bus.i_start = 1'b1;
        bus.i_rand  = 4'h3;
        @(posedge i_clk);
        #1;
        bus.i_start = 1'b0;
        done_seen = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c % 5 == 0) bus.i_rand = (bus.i_rand == 4'h3) ? 4'h7 : 4'h3;
            @(posedge i_clk);
            #1;
            if (bus.o_done !== 1'b0) done_seen++;
        end
        checks++; if (done_seen != 0) begin failures++; $display("FAIL toggle_no_settle: got %0d pulses exp 0", done_seen); end
        bus.i_rand = 4'h9;
        @(posedge i_clk);
        #1;
        wait_done(40, n);
        checks++; if (n != 16) begin failures++; $display("FAIL toggle_latency: got %0d exp 16", n); end
        checks++; if (bus.o_result !== 4'h9) begin failures++; $display("FAIL toggle_result: got %0h exp 9", bus.o_result); end
        checks++; if (bus.o_seg !== 7'h10) begin failures++; $display("FAIL toggle_seg: got %0h exp 10", bus.o_seg); end
        checks++; if (bus.o_rolls !== 8'd2) begin failures++; $display("FAIL toggle_rolls: got %0d exp 2", bus.o_rolls); end
    endtask

    task automatic test_reroll();
        int n;
        int done_seen;
        bus.i_start = 1'b1;
        bus.i_rand  = 4'h6;
        @(posedge i_clk);
        #1;
        bus.i_start = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge i_clk);
            #1;
            if (bus.o_done !== 1'b0) done_seen++;
        end
        bus.i_start = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_start = 1'b0;
        wait_done(40, n);
        checks++; if (done_seen != 0) begin failures++; $display("FAIL reroll_early: got %0d pulses exp 0", done_seen); end
        checks++; if (n != 16) begin failures++; $display("FAIL reroll_latency: got %0d exp 16", n); end
        checks++; if (bus.o_rolls !== 8'd3) begin failures++; $display("FAIL reroll_rolls: got %0d exp 3", bus.o_rolls); end
    endtask

    task automatic test_hist();
        int n;
        logic [15:0] exp_first;
        logic [15:0] exp_final;
`ifdef ROLL_CAPTURE_HIST_EN
        exp_first = 16'h0001;
        exp_final = 16'h234A;
`else
        exp_first = 16'h0000;
        exp_final = 16'h0000;
`endif
        apply_reset();
        do_roll(4'h1, n);
        checks++; if (bus.o_hist !== exp_first) begin failures++; $display("FAIL hist_first: got %0h exp %0h", bus.o_hist, exp_first); end
        do_roll(4'h2, n);
        do_roll(4'h3, n);
        do_roll(4'h4, n);
        do_roll(4'hA, n);
        checks++; if (n != 16) begin failures++; $display("FAIL hist_latency: got %0d exp 16", n); end
        checks++; if (bus.o_hist !== exp_final) begin failures++; $display("FAIL hist_final: got %0h exp %0h", bus.o_hist, exp_final); end
        checks++; if (bus.o_rolls !== 8'd5) begin failures++; $display("FAIL hist_rolls: got %0d exp 5", bus.o_rolls); end
        checks++; if (bus.o_seg !== 7'h08) begin failures++; $display("FAIL hist_seg: got %0h exp 08", bus.o_seg); end
    endtask

    task automatic test_saturate();
        int n;
        int timeouts;
        timeouts = 0;
        for (int i = 0; i < 250; i++) begin
            do_roll(4'(i), n);
            if (n != 16) timeouts++;
        end
        checks++; if (timeouts != 0) begin failures++; $display("FAIL sat_latency: got %0d bad rolls exp 0", timeouts); end
        checks++; if (bus.o_rolls !== 8'd255) begin failures++; $display("FAIL sat_reach: got %0d exp 255", bus.o_rolls); end
        do_roll(4'hE, n);
        checks++; if (bus.o_rolls !== 8'd255) begin failures++; $display("FAIL sat_hold: got %0d exp 255", bus.o_rolls); end
        checks++; if (bus.o_seg !== 7'h06) begin failures++; $display("FAIL sat_seg: got %0h exp 06", bus.o_seg); end
    endtask

    task automatic test_reset_mid_track();
        int done_seen;
        bus.i_start = 1'b1;
        bus.i_rand  = 4'h8;
        @(posedge i_clk);
        #1;
        bus.i_start = 1'b0;
        repeat (8) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++; if (bus.dbg_state !== ST_IDLE) begin failures++; $display("FAIL mid_state: got %0d exp %0d", bus.dbg_state, ST_IDLE); end
        checks++; if (bus.o_result !== 4'h0) begin failures++; $display("FAIL mid_result: got %0h exp 0", bus.o_result); end
        checks++; if (bus.o_done !== 1'b0) begin failures++; $display("FAIL mid_done: got %0b exp 0", bus.o_done); end
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL mid_valid: got %0b exp 0", bus.o_valid); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %0b exp 0", bus.o_busy); end
        checks++; if (bus.o_seg !== 7'h7F) begin failures++; $display("FAIL mid_seg: got %0h exp 7f", bus.o_seg); end
        checks++; if (bus.o_rolls !== 8'h00) begin failures++; $display("FAIL mid_rolls: got %0h exp 0", bus.o_rolls); end
        checks++; if (bus.o_hist !== 16'h0000) begin failures++; $display("FAIL mid_hist: got %0h exp 0", bus.o_hist); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge i_clk);
            #1;
            if (bus.o_done !== 1'b0) done_seen++;
        end
        checks++; if (done_seen != 0) begin failures++; $display("FAIL mid_no_done: got %0d pulses exp 0", done_seen); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL mid_stay_idle: got %0b exp 0", bus.o_busy); end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        i_rst_n     = 1'b0;
        bus.i_start = 1'b0;
        bus.i_rand  = 4'h0;
        test_reset();
        test_single_roll();
        test_toggle();
        test_reroll();
        test_hist();
        test_saturate();
        test_reset_mid_track();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
